// File: rtl/led_pattern_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_pattern_seq_pkg
//  Shared encodings for the LED pattern sequencer: step modes, bounce
//  direction and the pattern shown after reset or after loading an all-zero
//  seed.
// ----------------------------------------------------------------------------
package led_pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [15:0] RESET_PATTERN = 16'h0001;

endpackage : led_pattern_seq_pkg

// File: rtl/led_pattern_seq_btn_sync_edge.sv
// ----------------------------------------------------------------------------
// btn_sync_edge
//  Brings an asynchronous push-button level into the clk domain with a
//  2-flop synchroniser and turns each rising edge into a single-cycle,
//  registered pulse. The pulse is high during the third cycle after the
//  button rises.
// Ports
//  clk      in   system clock
//  rst      in   synchronous, active-high reset
//  btn_i    in   raw (asynchronous) button level
//  pulse_o  out  1-cycle pulse per rising edge of btn_i
// ----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;
  logic pulse_q;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      pulse_q <= sync2_q & ~hist_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule : btn_sync_edge

// File: rtl/led_pattern_seq.sv
// ----------------------------------------------------------------------------
// led_pattern_seq
//  Generates the 16-bit LED word for the serial LED driver (hexs[15] is the
//  leftmost LED) and advances it once every STEP_DIV clocks in one of four
//  modes: rotate-left, rotate-right, bounce, blink. A button press loads the
//  switch pattern as a new seed. hexs is registered, so the driver may sample
//  it on any cycle.
// Parameters
//  STEP_DIV  clk cycles per pattern step (>= 2)
//  CNT_W     prescaler width, 2**CNT_W >= STEP_DIV
// Ports
//  clk        in   system clock
//  rst        in   synchronous, active-high reset
//  mode       in   step mode, used only when a step happens
//  pause      in   freezes pattern, direction and prescaler
//  load_btn   in   asynchronous button level; rising edge loads sw
//  sw         in   seed pattern (all-zero seed loads 16'h0001)
//  hexs       out  current LED pattern (registered)
//  step_tick  out  1-cycle strobe, high while hexs shows a freshly stepped value
// ----------------------------------------------------------------------------
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int STEP_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        pause,
  input  logic        load_btn,
  input  logic [15:0] sw,
  output logic [15:0] hexs,
  output logic        step_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [15:0]      hexs_q, hexs_d;
  dir_e             dir_q,  dir_d;
  logic             step_tick_q, step_tick_d;
  logic             load_pulse;
  logic             tick;

  btn_sync_edge u_load_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (load_btn),
    .pulse_o (load_pulse)
  );

  // A paused prescaler never reaches its wrap, so pause also suppresses steps.
  assign tick = !pause && (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    cnt_d       = cnt_q;
    hexs_d      = hexs_q;
    dir_d       = dir_q;
    step_tick_d = 1'b0;

    if (load_pulse) begin
      // A load wins over a coincident step and restarts the step period.
      hexs_d = (sw == 16'h0000) ? RESET_PATTERN : sw;
      cnt_d  = '0;
      dir_d  = DIR_LEFT;
    end else if (tick) begin
      cnt_d       = '0;
      step_tick_d = 1'b1;
      case (mode_e'(mode))
        MODE_ROTL: hexs_d = {hexs_q[14:0], hexs_q[15]};
        MODE_ROTR: hexs_d = {hexs_q[0], hexs_q[15:1]};
        MODE_BOUNCE: begin
          // An all-zero word has nothing to bounce; it holds with dir intact.
          if (hexs_q != 16'h0000) begin
            if (dir_q == DIR_LEFT) begin
              if (hexs_q[15]) begin
                dir_d  = DIR_RIGHT;
                hexs_d = hexs_q >> 1;
              end else begin
                hexs_d = hexs_q << 1;
              end
            end else begin
              if (hexs_q[0]) begin
                dir_d  = DIR_LEFT;
                hexs_d = hexs_q << 1;
              end else begin
                hexs_d = hexs_q >> 1;
              end
            end
          end
        end
        MODE_BLINK: hexs_d = ~hexs_q;
        default: hexs_d = hexs_q;
      endcase
    end else if (!pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      hexs_q      <= RESET_PATTERN;
      dir_q       <= DIR_LEFT;
      step_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hexs_q      <= hexs_d;
      dir_q       <= dir_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign hexs      = hexs_q;
  assign step_tick = step_tick_q;

endmodule : led_pattern_seq

// File: tb/tb_led_pattern_seq.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_seq
//  Drives directed scenarios followed by randomized traffic into
//  led_pattern_seq (STEP_DIV=4). A behavioural model tracks the expected LED
//  word every cycle and pushes each stepped pattern into a scoreboard queue; a
//  monitor pops one entry whenever the DUT raises step_tick.
// ----------------------------------------------------------------------------
module tb_led_pattern_seq;

  localparam int STEP_DIV = 4;
  localparam int CNT_W    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        pause = 1'b0;
  logic        load_btn = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [15:0] hexs;
  logic        step_tick;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state.
  int   m_pat   = 1;
  int   m_dir   = 0;   // 0 = moving left, 1 = moving right
  int   m_cnt   = 0;
  int   m_stick = 0;
  logic [3:0] m_btn_hist = '0;  // [0] = last clock's button sample
  int   sb_q[$];

  led_pattern_seq #(.STEP_DIV(STEP_DIV), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .pause     (pause),
    .load_btn  (load_btn),
    .sw        (sw),
    .hexs      (hexs),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pattern step expressed with plain integer arithmetic.
  function automatic void model_step(input int md, inout int p, inout int d);
    case (md)
      0: p = (p * 2) % 65536 + p / 32768;
      1: p = p / 2 + (p % 2) * 32768;
      2: begin
        if (p != 0) begin
          if (d == 0) begin
            if (p >= 32768) begin d = 1; p = p / 2; end
            else p = (p * 2) % 65536;
          end else begin
            if (p % 2 == 1) begin d = 0; p = (p * 2) % 65536; end
            else p = p / 2;
          end
        end
      end
      default: p = 65535 - p;
    endcase
  endfunction

  // Reference model: a press is seen as a load 4 clocks after the button
  // rises; a step happens every STEP_DIV unpaused clocks.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pat = 1; m_dir = 0; m_cnt = 0; m_stick = 0; m_btn_hist = '0;
      end else begin
        logic ld;
        ld = m_btn_hist[2] & ~m_btn_hist[3];
        m_btn_hist = {m_btn_hist[2:0], load_btn};
        m_stick = 0;
        if (ld) begin
          m_pat = (sw == 16'h0000) ? 1 : int'(sw);
          m_cnt = 0;
          m_dir = 0;
        end else if (!pause) begin
          if (m_cnt == STEP_DIV - 1) begin
            m_cnt = 0;
            model_step(int'(mode), m_pat, m_dir);
            m_stick = 1;
            sb_q.push_back(m_pat);
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Monitor: compares every cycle against the model and consumes one
  // scoreboard entry per DUT step strobe.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("hexs_vs_model", 32'(hexs), m_pat);
      check("step_tick_vs_model", 32'(step_tick), m_stick);
      if (step_tick === 1'b1) begin
        check("sb_entry_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) check("sb_step_pattern", 32'(hexs), sb_q.pop_front());
      end
    end
  end

  // Waits (bounded) for the next step strobe; returns on a negedge.
  task automatic wait_step();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step_tick === 1'b1) break;
    end
    check("step_tick_timeout", 32'(step_tick), 32'd1);
  endtask

  // Presses the button with a seed; hexs must show expv 4 clocks later.
  task automatic press(input logic [15:0] seed, input logic [15:0] expv);
    @(negedge clk);
    sw = seed;
    load_btn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("load_latency", 32'(hexs), 32'(expv));
    @(negedge clk);
    load_btn = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    // 1: reset values and rotate-left wrap.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hexs", 32'(hexs), 32'h0001);
    check("reset_step_tick", 32'(step_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rotl_first_step", 32'(hexs), 32'h0002);
    repeat (60) @(posedge clk);
    #1;
    check("rotl_full_circle", 32'(hexs), 32'h0001);

    // 2: seed load and zero-seed substitution.
    press(16'hA5F0, 16'hA5F0);
    press(16'h0000, 16'h0001);

    // 3: bounce from the left edge, then a full sweep with reversal.
    mode = 2'b10;
    press(16'h8000, 16'h8000);
    wait_step(); check("bounce_8000_a", 32'(hexs), 32'h4000);
    wait_step(); check("bounce_8000_b", 32'(hexs), 32'h2000);
    press(16'h0001, 16'h0001);
    for (int i = 1; i < 16; i++) begin
      wait_step();
      check("bounce_sweep", 32'(hexs), 32'h1 << i);
    end
    wait_step(); check("bounce_reverse", 32'(hexs), 32'h4000);

    // 4: blink then rotate-right.
    @(negedge clk); mode = 2'b11;
    press(16'h00FF, 16'h00FF);
    wait_step(); check("blink_a", 32'(hexs), 32'hFF00);
    wait_step(); check("blink_b", 32'(hexs), 32'h00FF);
    mode = 2'b01;
    wait_step(); check("rotr_from_00ff", 32'(hexs), 32'h807F);

    // 5: pause freezes everything; load colliding with a step.
    @(negedge clk); pause = 1'b1;
    begin
      int held;
      held = m_pat;
      repeat (20) begin
        @(negedge clk);
        check("pause_hexs", 32'(hexs), held);
        check("pause_no_step", 32'(step_tick), 32'd0);
      end
    end
    pause = 1'b0;
    wait_step();
    mode = 2'b11;
    sw = 16'h1234;
    load_btn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("collision_seed", 32'(hexs), 32'h1234);
    @(negedge clk);
    check("collision_no_step", 32'(step_tick), 32'd0);
    load_btn = 1'b0;
    wait_step(); check("collision_next_step", 32'(hexs), 32'hEDCB);

    // 6: reset while bouncing right clears dir back to LEFT.
    mode = 2'b10;
    press(16'h8000, 16'h8000);
    wait_step(); check("bounce_before_rst", 32'(hexs), 32'h4000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_rst_hexs", 32'(hexs), 32'h0001);
    @(negedge clk);
    check("midrun_rst_step_tick", 32'(step_tick), 32'd0);
    rst = 1'b0;
    mode = 2'b00;
    wait_step(); check("post_rst_rotl", 32'(hexs), 32'h0002);
    mode = 2'b10;
    wait_step(); check("post_rst_dir_left", 32'(hexs), 32'h0004);

    // Randomized traffic, checked by the model and scoreboard.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) load_btn = ~load_btn;
      if ($urandom_range(0, 9) == 0)
        sw = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    pause = 1'b0;
    load_btn = 1'b0;
    repeat (12) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_led_pattern_seq
